// File: rtl/pos_sweep_pkg.sv
// Shared types and sizes for the truth-table sweep sequencer.
package pos_sweep_pkg;

    localparam int unsigned NUM_COMBOS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned ERR_W      = 4;
    localparam int unsigned SETTLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/pos_sweep_check.sv
// Compares each captured sample with the latched expected mask and tracks errors.
module pos_sweep_check
    import pos_sweep_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  sample,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  f_in,
    input  logic [NUM_COMBOS-1:0] mask_in,
    output logic [ERR_W-1:0]      err_count,
    output logic [IDX_W-1:0]      first_err_idx,
    output logic                  mismatch
);

    logic [NUM_COMBOS-1:0] mask_q, mask_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [IDX_W-1:0]      first_q, first_d;
    logic                  mism_q, mism_d;

    always_comb begin
        mask_d  = mask_q;
        err_d   = err_q;
        first_d = first_q;
        if (clear) begin
            mask_d  = mask_in;
            err_d   = '0;
            first_d = '0;
        end else if (sample && (f_in != mask_q[idx])) begin
            err_d = err_q + ERR_W'(1);
            // a zero count means no earlier error in this sweep
            if (err_q == '0) begin
                first_d = idx;
            end
        end
        mism_d = (err_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            mism_q  <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            err_q   <= err_d;
            first_q <= first_d;
            mism_q  <= mism_d;
        end
    end

    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign mismatch      = mism_q;

endmodule

// File: rtl/pos_sweep_ctrl.sv
// Sweeps a 3-input evaluator through all combinations and captures its truth vector.
// Define POS_SWEEP_CHECK_EN to build the expected-mask compare logic.
module pos_sweep_ctrl
    import pos_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_COMBOS-1:0] expect_mask,
    input  logic                  f_in,
    output logic [IDX_W-1:0]      abc,
    output logic [NUM_COMBOS-1:0] truth,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic [ERR_W-1:0]      err_count,
    output logic [IDX_W-1:0]      first_err_idx
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic [NUM_COMBOS-1:0] truth_q, truth_d;
    logic [IDX_W-1:0]      abc_q, abc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  clear_c;
    logic                  sample_c;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        truth_d  = truth_q;
        clear_c  = 1'b0;
        sample_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    truth_d = '0;
                    clear_c = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == SETTLE_W'(SETTLE - 1)) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                // an aborted sample is dropped, earlier captures are kept
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sample_c       = 1'b1;
                    truth_d[idx_q] = f_in;
                    if (idx_q == IDX_W'(NUM_COMBOS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = DRIVE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        abc_d  = busy_d ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            truth_q <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            truth_q <= truth_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign abc   = abc_q;
    assign truth = truth_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef POS_SWEEP_CHECK_EN
    pos_sweep_check u_check (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear_c),
        .sample        (sample_c),
        .idx           (idx_q),
        .f_in          (f_in),
        .mask_in       (expect_mask),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .mismatch      (mismatch)
    );
`else
    logic unused_chk;
    assign unused_chk    = ^{expect_mask, clear_c, sample_c};
    assign err_count     = '0;
    assign first_err_idx = '0;
    assign mismatch      = 1'b0;
`endif

endmodule
